// File: rtl/pipe_skid_stage.sv
// Two-entry skid buffer stage: a main register drives out_data, a skid register
// absorbs one extra beat so in_ready depends on registered state only.
module pipe_skid_stage #(
  parameter int WIDTH          = 32,
  parameter int CLEAR_ON_FLUSH = 1,
  parameter int CNT_W          = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cnt
);

  // Handshake: a beat transfers on a rising edge where valid & ready are both 1;
  // valid never waits for ready, and ready/valid here come from state_q only.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             in_fire, out_fire;

  assign in_ready  = (state_q != ST_FULL);
  assign out_valid = (state_q != ST_EMPTY);
  assign out_data  = main_q;
  assign stall_cnt = stall_cnt_q;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  always_comb begin
    occupancy = 2'd0;
    case (state_q)
      ST_ONE:  occupancy = 2'd1;
      ST_FULL: occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      // Flush overrides both handshakes; any offered beat is dropped.
      state_d = ST_EMPTY;
      if (CLEAR_ON_FLUSH != 0) begin
        main_d = '0;
        skid_d = '0;
      end
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            main_d  = in_data;
            state_d = ST_ONE;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            main_d = in_data;
          end else if (in_fire) begin
            skid_d  = in_data;
            state_d = ST_FULL;
          end else if (out_fire) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (out_fire) begin
            main_d  = skid_q;
            state_d = ST_ONE;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // Stall counter saturates and deliberately survives flush.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (out_valid && !out_ready && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= ST_EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Bench for pipe_skid_stage: directed scenarios plus a randomized run, all
// checked against a queue-based reference model of the held entries.
module tb_pipe_skid_stage;

  localparam int W  = 8;
  localparam int CW = 4;
  localparam int STALL_MAX = (1 << CW) - 1;

  logic          CLK = 1'b0;
  logic          nRST;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [1:0]    occupancy;
  logic [CW-1:0] stall_cnt;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: entries in acceptance order, last shown payload, stall count.
  logic [W-1:0] exp_q[$];
  logic [W-1:0] last_front;
  int           exp_stall;

  pipe_skid_stage #(.WIDTH(W), .CLEAR_ON_FLUSH(1), .CNT_W(CW)) dut (
    .CLK(CLK), .nRST(nRST), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy), .stall_cnt(stall_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear(input bit clr_stall);
    exp_q.delete();
    last_front = '0;
    if (clr_stall) exp_stall = 0;
  endtask

  task automatic check_all(input string tag);
    int sz;
    sz = exp_q.size();
    check({tag, ".in_ready"},  32'(in_ready),  32'(sz < 2));
    check({tag, ".out_valid"}, 32'(out_valid), 32'(sz > 0));
    check({tag, ".occupancy"}, 32'(occupancy), 32'(sz));
    check({tag, ".out_data"},  32'(out_data),  32'((sz > 0) ? exp_q[0] : last_front));
    check({tag, ".stall_cnt"}, 32'(stall_cnt), 32'(exp_stall));
  endtask

  // One clock: drive at negedge, probe for combinational feed-through, then
  // advance the model and compare just after the rising edge.
  task automatic step(input logic iv, input logic [W-1:0] d, input logic ordy, input logic fl);
    logic ir_a, ir_b, ov_a, ov_b;
    bit   inf, outf;
    int   sz;
    @(negedge CLK);
    flush = fl; in_valid = iv; in_data = d; out_ready = ~ordy;
    #1;
    ir_a = in_ready; ov_a = out_valid;
    out_ready = ordy; in_valid = ~iv;
    #1;
    ir_b = in_ready; ov_b = out_valid;
    in_valid = iv;
    #1;
    check("ready_path", 32'(ir_b), 32'(ir_a));
    check("valid_path", 32'(ov_b), 32'(ov_a));
    sz   = exp_q.size();
    inf  = iv && (sz < 2);
    outf = (sz > 0) && ordy;
    if (sz > 0 && !ordy && exp_stall < STALL_MAX) exp_stall++;
    if (fl) begin
      model_clear(1'b0);
    end else begin
      if (outf) void'(exp_q.pop_front());
      if (inf) exp_q.push_back(d);
      if (exp_q.size() > 0) last_front = exp_q[0];
    end
    @(posedge CLK);
    #1;
    check_all("cyc");
  endtask

  initial begin
    nRST = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    model_clear(1'b1);
    #3;
    check_all("reset");
    @(negedge CLK);
    nRST = 1'b1;

    // Streaming with out_ready=1: one beat per cycle, occupancy stays 1.
    for (int i = 1; i <= 5; i++) begin
      step(1'b1, W'(i), 1'b1, 1'b0);
      check("stream_data", 32'(out_data), 32'(i));
      check("stream_occ", 32'(occupancy), 32'd1);
    end
    step(1'b0, '0, 1'b1, 1'b0);

    // Back-pressure fills the skid, then drains in order.
    step(1'b1, 8'hA1, 1'b0, 1'b0);
    step(1'b1, 8'hA2, 1'b0, 1'b0);
    check("bp_occ", 32'(occupancy), 32'd2);
    check("bp_in_ready", 32'(in_ready), 32'd0);
    check("bp_head", 32'(out_data), 32'hA1);
    step(1'b0, '0, 1'b1, 1'b0);
    check("bp_second", 32'(out_data), 32'hA2);
    step(1'b0, '0, 1'b1, 1'b0);

    // Flush while FULL with an offered beat: everything vanishes.
    step(1'b1, 8'hB1, 1'b0, 1'b0);
    step(1'b1, 8'hB2, 1'b0, 1'b0);
    step(1'b1, 8'hC3, 1'b0, 1'b1);
    check("flush_occ", 32'(occupancy), 32'd0);
    check("flush_valid", 32'(out_valid), 32'd0);
    check("flush_data", 32'(out_data), 32'h00);
    step(1'b0, '0, 1'b1, 1'b0);
    check("flush_gone", 32'(out_valid), 32'd0);

    // Asynchronous reset pulse between edges while FULL.
    step(1'b1, 8'hD1, 1'b0, 1'b0);
    step(1'b1, 8'hD2, 1'b0, 1'b0);
    @(negedge CLK);
    in_valid = 1'b0; out_ready = 1'b0;
    #1 nRST = 1'b0;
    #1;
    check("arst_in_ready", 32'(in_ready), 32'd1);
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_stall", 32'(stall_cnt), 32'd0);
    check("arst_data", 32'(out_data), 32'd0);
    model_clear(1'b1);
    #1 nRST = 1'b1;
    step(1'b1, 8'hE1, 1'b1, 1'b0);
    check("arst_after", 32'(out_data), 32'hE1);

    // Stall counter saturates and survives flush.
    for (int i = 0; i < 20; i++) step(1'b0, '0, 1'b0, 1'b0);
    check("stall_sat", 32'(stall_cnt), 32'd15);
    step(1'b0, '0, 1'b0, 1'b1);
    check("stall_keep", 32'(stall_cnt), 32'd15);

    // Randomized traffic with occasional flushes.
    for (int i = 0; i < 10000; i++) begin
      step(1'($urandom_range(0, 1)), W'($urandom_range(0, 255)),
           1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 199) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/pipe_skid_stage.md
PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

Interface
REQ-001 The module SHALL have parameter WIDTH, default 32, meaning the payload width in bits (minimum 1).
REQ-002 The module SHALL have parameter CLEAR_ON_FLUSH, default 1, meaning flush zeroes both data registers when 1 and leaves them unchanged when 0.
REQ-003 The module SHALL have parameter CNT_W, default 16, meaning the stall counter width.
REQ-004 The module SHALL have port CLK  input  1  meaning the single clock; all state updates on its rising edge.
REQ-005 The module SHALL have port nRST  input  1  meaning the reset, asynchronous and active-low.
REQ-006 The module SHALL have port flush  input  1  meaning a synchronous stage clear, active-high.
REQ-007 The module SHALL have port in_valid  input  1  meaning the upstream stage presents in_data.
REQ-008 The module SHALL have port in_ready  output  1  meaning the stage accepts in_data this cycle.
REQ-009 The module SHALL have port in_data  input  WIDTH  meaning the upstream payload.
REQ-010 The module SHALL have port out_valid  output  1  meaning out_data holds a valid entry.
REQ-011 The module SHALL have port out_ready  input  1  meaning the downstream stage accepts out_data this cycle.
REQ-012 The module SHALL have port out_data  output  WIDTH  meaning the oldest held payload.
REQ-013 The module SHALL have port occupancy  output  2  meaning the number of held entries (0, 1 or 2).
REQ-014 The module SHALL have port stall_cnt  output  CNT_W  meaning a saturating count of cycles with out_valid=1 and out_ready=0.

Function
REQ-015 The stage SHALL hold a main register (drives out_data) and a skid register, with states EMPTY, ONE and FULL.
REQ-016 The stage SHALL define in_fire = in_valid & in_ready and out_fire = out_valid & out_ready.
REQ-017 The stage SHALL derive in_ready = (state != FULL) and out_valid = (state != EMPTY) from registered state only, with no combinational path from out_ready to in_ready or from in_valid to out_valid.
REQ-018 In EMPTY, in_fire SHALL load main with in_data and go to ONE; otherwise the stage SHALL stay in EMPTY.
REQ-019 In ONE, in_fire with out_fire SHALL load main with in_data and stay in ONE.
REQ-020 In ONE, in_fire without out_fire SHALL load skid with in_data and go to FULL.
REQ-021 In ONE, out_fire without in_fire SHALL go to EMPTY.
REQ-022 In ONE, neither fire SHALL hold the state.
REQ-023 In FULL, out_fire SHALL copy skid into main and go to ONE; otherwise the stage SHALL hold FULL.
REQ-024 Latency from in_fire in EMPTY to out_valid SHALL be exactly 1 cycle.
REQ-025 Sustained throughput with in_valid=1 and out_ready=1 SHALL be 1 entry per cycle.
REQ-026 Entries SHALL leave in acceptance order, with none dropped or duplicated.
REQ-027 Flush SHALL have highest priority: state goes to EMPTY, in_fire and out_fire that cycle are discarded, and both registers are zeroed if CLEAR_ON_FLUSH=1.
REQ-028 in_ready SHALL remain as given by the current state during a flush cycle; an entry offered in that cycle is lost by design.
REQ-029 The occupancy output SHALL equal 0, 1 or 2 for EMPTY, ONE or FULL respectively.
REQ-030 stall_cnt SHALL increment when out_valid=1 and out_ready=0, SHALL saturate at 2^CNT_W-1, and SHALL NOT be cleared by flush.

Reset
REQ-031 When nRST=0, asynchronously and regardless of CLK, the stage SHALL set state=EMPTY, main=0, skid=0 and stall_cnt=0.
REQ-032 During reset, outputs SHALL read in_ready=1, out_valid=0, out_data=0, occupancy=0 and stall_cnt=0.
REQ-033 Reset asserted mid-transfer SHALL discard all held entries, and the first edge after release SHALL behave as EMPTY.

Verification
REQ-034 With WIDTH=8 and out_ready=1, streaming in_data 0x01..0x05 on consecutive cycles SHALL produce out_data 0x01..0x05 one cycle later with occupancy=1 throughout.
REQ-035 With out_ready=0 and in_data 0xA1 then 0xA2 offered, the stage SHALL show occupancy=2 and in_ready=0; raising out_ready SHALL output 0xA1 then 0xA2.
REQ-036 In FULL with flush=1 and in_valid=1, the next cycle SHALL show occupancy=0, out_valid=0 and out_data=0x00, and the offered entry SHALL never appear.
REQ-037 With CNT_W=4 and out_valid=1, holding out_ready=0 for 20 cycles SHALL give stall_cnt=15, and a following flush SHALL leave it at 15.
REQ-038 Pulsing nRST low between edges while in FULL SHALL immediately show in_ready=1, out_valid=0 and stall_cnt=0.
REQ-039 With randomised in_valid and out_ready for 10,000 cycles, the output sequence SHALL equal the accepted input sequence, with no combinational out_ready-to-in_ready path.
